// File: rtl/ins_loader.sv
// Boot-time program loader: assembles a length-prefixed, XOR-checksummed byte
// stream into 16-bit words, writes them to instruction memory from address 0 up.
module ins_loader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   word_cnt
);

  typedef enum logic [2:0] {
    S_LEN, S_HI, S_LO, S_WR, S_CHK, S_DONE, S_ERR
  } state_t;

  state_t      state, state_next;
  logic [7:0]  length;
  logic [7:0]  checksum;
  logic        accept;
  logic        last_word;

  assign accept    = in_valid & in_ready;
  // length is >= 1 whenever S_WR is reachable, so length-1 never underflows here
  assign last_word = ({1'b0, mem_addr} == ((ADDR_W+1)'(length) - (ADDR_W+1)'(1)));
  assign cpu_rst   = rst | ~done;

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    busy       = 1'b0;
    case (state)
      S_LEN: begin
        in_ready = 1'b1;
        if (accept) state_next = (in_data == 8'd0) ? S_CHK : S_HI;
      end
      S_HI: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (accept) state_next = S_LO;
      end
      S_LO: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (accept) state_next = S_WR;
      end
      S_WR: begin
        busy       = 1'b1;
        state_next = last_word ? S_CHK : S_HI;
      end
      S_CHK: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (accept) state_next = (in_data == checksum) ? S_DONE : S_ERR;
      end
      S_DONE, S_ERR: begin
        if (start) state_next = S_LEN;
      end
      default: state_next = S_LEN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_LEN;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      word_cnt  <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      checksum  <= '0;
      length    <= '0;
    end else begin
      state  <= state_next;
      // registered write strobe: high exactly for the one cycle spent in S_WR
      mem_we <= (state_next == S_WR);
      case (state)
        S_LEN: begin
          if (accept) begin
            length   <= in_data;
            checksum <= in_data;
          end
        end
        S_HI: begin
          if (accept) begin
            mem_wdata[DATA_W-1 -: 8] <= in_data;
            checksum                 <= checksum ^ in_data;
          end
        end
        S_LO: begin
          if (accept) begin
            mem_wdata[7:0] <= in_data;
            checksum       <= checksum ^ in_data;
          end
        end
        S_WR: begin
          word_cnt <= word_cnt + 1'b1;
          if (!last_word) mem_addr <= mem_addr + 1'b1;
        end
        S_CHK: begin
          if (accept) begin
            done <= (in_data == checksum);
            err  <= (in_data != checksum);
          end
        end
        S_DONE, S_ERR: begin
          if (start) begin
            mem_addr <= '0;
            word_cnt <= '0;
            checksum <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ins_loader.sv
// Scoreboard bench for ins_loader: expected memory writes are queued from the
// stream contents and popped by an independent write monitor.
module tb_ins_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        cpu_rst;
  logic        busy;
  logic        done;
  logic        err;
  logic [8:0]  word_cnt;

  ins_loader #(.ADDR_W(8), .DATA_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_rst(cpu_rst), .busy(busy), .done(done), .err(err), .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  addr;
    logic [15:0] data;
  } wr_t;

  wr_t         exp_q[$];
  logic [15:0] words_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          last_wr_addr = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Write monitor: every mem_we pulse must match the oldest outstanding expected write
  always @(negedge clk) begin
    if (!rst) begin
      if (busy) chk("ready_vs_we", {31'd0, in_ready}, {31'd0, ~mem_we});
      if (mem_we) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 32'd1, 32'd0);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("wr_addr", {24'd0, mem_addr}, {24'd0, e.addr});
          chk("wr_data", {16'd0, mem_wdata}, {16'd0, e.data});
          $display("write addr=%02h data=%04h", mem_addr, mem_wdata);
          last_wr_addr = int'(mem_addr);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    while (gaps && ($urandom_range(0, 1) == 1)) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = b;
    for (int t = 0; t < 50; t++) begin
      if (in_ready) begin
        @(negedge clk);
        in_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("accept_timeout", 32'd1, 32'd0);
  endtask

  // Sends the image held in words_q; only words whose bytes are all sent are expected.
  task automatic stream(input bit gaps, input logic [7:0] corrupt, input int max_bytes);
    logic [7:0] bytes_q[$];
    logic [7:0] ck;
    int n;
    n = words_q.size();
    ck = 8'(n);
    bytes_q.push_back(8'(n));
    for (int i = 0; i < n; i++) begin
      bytes_q.push_back(words_q[i][15:8]);
      bytes_q.push_back(words_q[i][7:0]);
      ck = ck ^ words_q[i][15:8] ^ words_q[i][7:0];
      if (3 + 2 * i <= max_bytes) exp_q.push_back({8'(i), words_q[i]});
    end
    bytes_q.push_back(ck ^ corrupt);
    for (int i = 0; i < bytes_q.size() && i < max_bytes; i++) send_byte(bytes_q[i], gaps);
  endtask

  task automatic finish_check(input string tag, input bit ok, input int n);
    int t;
    t = 0;
    while (!(done | err) && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_done"}, {31'd0, done}, {31'd0, ok});
    chk({tag, "_err"}, {31'd0, err}, {31'd0, ~ok});
    chk({tag, "_cpu_rst"}, {31'd0, cpu_rst}, {31'd0, ~ok});
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
    chk({tag, "_word_cnt"}, {23'd0, word_cnt}, 32'(n));
    chk({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
    $display("load %s: n=%0d done=%0b err=%0b word_cnt=%0d", tag, n, done, err, word_cnt);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("rearm_done", {31'd0, done}, 32'd0);
    chk("rearm_err", {31'd0, err}, 32'd0);
    chk("rearm_cnt", {23'd0, word_cnt}, 32'd0);
    chk("rearm_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    chk("rearm_ready", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_we"}, {31'd0, mem_we}, 32'd0);
    chk({tag, "_addr"}, {24'd0, mem_addr}, 32'd0);
    chk({tag, "_wdata"}, {16'd0, mem_wdata}, 32'd0);
    chk({tag, "_cnt"}, {23'd0, word_cnt}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_err"}, {31'd0, err}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_cpu_rst"}, {31'd0, cpu_rst}, 32'd1);
  endtask

  task automatic load_two_words();
    words_q = {};
    words_q.push_back(16'h1234);
    words_q.push_back(16'hABCD);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;
    @(negedge clk);
    chk("idle_ready", {31'd0, in_ready}, 32'd1);
    chk("idle_busy", {31'd0, busy}, 32'd0);

    load_two_words();
    stream(1'b0, 8'h00, 1000);
    finish_check("two_words", 1'b1, 2);
    pulse_start();

    stream(1'b0, 8'h01, 1000);
    finish_check("bad_cksum", 1'b0, 2);
    pulse_start();
    stream(1'b0, 8'h00, 1000);
    finish_check("reload", 1'b1, 2);
    pulse_start();

    words_q = {};
    stream(1'b0, 8'h00, 1000);
    finish_check("empty", 1'b1, 0);
    pulse_start();

    load_two_words();
    stream(1'b1, 8'h00, 1000);
    finish_check("gaps", 1'b1, 2);
    pulse_start();

    stream(1'b0, 8'h00, 4);
    rst = 1'b1;
    #1;
    check_reset_values("midload");
    @(negedge clk);
    rst = 1'b0;
    chk("midload_pending", 32'(exp_q.size()), 32'd0);
    stream(1'b0, 8'h00, 1000);
    finish_check("after_rst", 1'b1, 2);
    pulse_start();

    words_q = {};
    for (int i = 0; i < 255; i++) words_q.push_back({8'(2 * i), 8'(2 * i + 1)});
    stream(1'b0, 8'h00, 1000);
    finish_check("full", 1'b1, 255);
    chk("full_last_addr", 32'(last_wr_addr), 32'd254);
    pulse_start();

    for (int r = 0; r < 6; r++) begin
      int n;
      logic [7:0] bad;
      n = $urandom_range(1, 12);
      bad = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      words_q = {};
      for (int i = 0; i < n; i++) words_q.push_back(16'($urandom));
      stream(1'b1, bad, 1000);
      finish_check("random", bad == 8'h00, n);
      pulse_start();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ins_loader.md
Name: ins_loader

Overview:
- Boot-time program loader directly upstream of the instruction memory / PC path of the single-cycle CPU.
- Receives a byte stream over a valid/ready handshake and assembles it into 16-bit instruction words.
- Writes each word into instruction memory from address 0 upward.
- Holds the CPU in reset until the image is fully loaded and its checksum verifies; the PC then starts at 0 on a valid program.

Parameters:
- ADDR_W, 8: instruction memory address width; matches the PC width.
- DATA_W, 16: instruction width. Fixed at 2 bytes per word; other values are unsupported.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle pulse; re-arms the loader from S_DONE or S_ERR.
- in_valid  input  1  in_data carries a valid byte.
- in_data  input  8  stream byte.
- in_ready  output  1  loader can accept a byte this cycle.
- mem_we  output  1  instruction memory write enable.
- mem_addr  output  ADDR_W  instruction memory write address.
- mem_wdata  output  DATA_W  instruction word to write.
- cpu_rst  output  1  reset to PC/register file; active-high.
- busy  output  1  a load is in progress.
- done  output  1  image loaded and checksum correct.
- err  output  1  checksum mismatch.
- word_cnt  output  ADDR_W+1  number of words written in the current or last load.

Behaviour:
- Clocking and reset:
  - One clock domain.
  - rst asynchronously clears all state: state=S_LEN, mem_we=0, mem_addr=0, mem_wdata=0, word_cnt=0, done=0, err=0, checksum=0, length=0.
- Handshake:
  - A byte is accepted on a rising edge where in_valid & in_ready.
  - in_ready is combinational from state: 1 in S_LEN, S_HI, S_LO, S_CHK; 0 in S_WR, S_DONE, S_ERR.
  - in_data is ignored when no byte is accepted.
- Stream format:
  - Byte 0 = length N (words, 0..255).
  - Then 2N data bytes, each word sent high byte first.
  - Final byte = checksum: XOR of the length byte and all data bytes.
- State machine:
  - S_LEN: on accept, latch N and checksum=byte. If N==0 go to S_CHK, else go to S_HI.
  - S_HI: on accept, mem_wdata[15:8]=byte, checksum^=byte, go to S_LO.
  - S_LO: on accept, mem_wdata[7:0]=byte, checksum^=byte, go to S_WR.
  - S_WR: lasts exactly one cycle with mem_we=1 and stable mem_addr/mem_wdata; word_cnt increments at the end of the cycle.
    - If mem_addr==N-1, go to S_CHK with mem_addr held.
    - Otherwise mem_addr increments and the state returns to S_HI.
  - S_CHK: on accept, if byte==checksum go to S_DONE, else go to S_ERR.
  - S_DONE: done=1. start → S_LEN, clearing mem_addr, word_cnt, checksum and done.
  - S_ERR: err=1. start → S_LEN with the same clearing as S_DONE, plus err cleared.
  - start is ignored in all states except S_DONE and S_ERR.
- Output timing:
  - mem_we is a registered output, high only in S_WR; the write latency is 1 cycle after the low byte is accepted.
  - Maximum throughput is one word per 3 cycles.
- Output definitions:
  - cpu_rst = rst | ~done, combinational. The CPU is released on the first cycle of S_DONE and re-held immediately on start or rst.
  - busy = 1 in S_LEN..S_CHK once a length byte has been accepted. busy=0 in S_LEN before the first byte, and in S_DONE and S_ERR.
- Boundary conditions:
  - N=255: the last write goes to address 254, and mem_addr never wraps during a load.
  - in_valid held high continuously: no byte is lost; the stream simply stalls during S_WR.
  - rst asserted mid-load: returns immediately to S_LEN with mem_we=0. Partially written memory contents are not cleaned up, and the CPU stays in reset.

Test Plan:
- Reset, then stream 02,12,34,AB,CD,checksum(02^12^34^AB^CD=42) with in_valid always high:
  - writes (0,1234) then (1,ABCD), each with mem_we high for 1 cycle;
  - done=1, cpu_rst=0, word_cnt=2.
- Same stream with checksum 43 → err=1, done=0, cpu_rst=1; then start plus the correct stream → done=1.
- Stream 00,00 → no mem_we pulses, done=1, word_cnt=0.
- Random in_valid gaps (50% duty) on the 2-word stream → identical writes and final state; in_ready=0 exactly in the S_WR cycles.
- Assert rst after the high byte of word 1 → all outputs at reset values, cpu_rst=1; a following full stream loads correctly.
- N=FF with 510 incrementing bytes → last write to address FE, word_cnt=255, done=1 on a correct checksum.
